// File: rtl/key_script_sequencer.sv
// Replays a small table of {space,right,left} key masks, each held for a number of ticks,
// into the game logic in place of a live keyboard.
module key_script_sequencer #(
  parameter int STEPS    = 16,
  parameter int DUR_W    = 20,
  parameter int TICK_DIV = 65_000,
  localparam int AW      = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       wr_keys,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             wr_last,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_en,
  output logic             key_space,
  output logic             key_right,
  output logic             key_left,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx
);

  localparam int PW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_PLAY   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  logic [2:0]       r_keys_mem [STEPS];
  logic [DUR_W-1:0] r_dur_mem  [STEPS];
  logic             r_last_mem [STEPS];

  state_t           r_state;
  logic [AW-1:0]    r_step;
  logic [2:0]       r_keys;
  logic [DUR_W-1:0] r_dur;
  logic             r_last;
  logic [PW-1:0]    r_pre;
  logic [DUR_W-1:0] r_tick;
  logic             r_busy;
  logic             r_done;

  logic             w_wr_ok;
  logic             w_pre_wrap;
  logic             w_step_end;
  logic             w_final;

  // Script table holds its contents across reset so a bench can preload it once.
  assign w_wr_ok = wr_en && (int'(wr_addr) < STEPS);

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_keys_mem[wr_addr] <= wr_keys;
      r_dur_mem[wr_addr]  <= wr_dur;
      r_last_mem[wr_addr] <= wr_last;
    end
  end

  assign w_pre_wrap = (r_pre == PW'(TICK_DIV - 1));
  assign w_step_end = w_pre_wrap && (r_tick == r_dur - DUR_W'(1));
  assign w_final    = r_last || (r_step == AW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_keys  <= '0;
      r_dur   <= DUR_W'(1);
      r_last  <= 1'b0;
      r_pre   <= '0;
      r_tick  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_keys  <= '0;
        r_pre   <= '0;
        r_tick  <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_keys <= '0;
            if (start && !abort) begin
              r_step  <= '0;
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end
          end
          // Entry is latched here, so rewrites of a playing entry only show at its next load.
          S_LOAD: begin
            r_keys  <= r_keys_mem[r_step];
            r_dur   <= (r_dur_mem[r_step] == '0) ? DUR_W'(1) : r_dur_mem[r_step];
            r_last  <= r_last_mem[r_step];
            r_pre   <= '0;
            r_tick  <= '0;
            r_state <= S_PLAY;
          end
          S_PLAY: begin
            if (w_pre_wrap) begin
              r_pre <= '0;
              if (w_step_end) begin
                r_tick <= '0;
                if (w_final) begin
                  if (loop_en) begin
                    r_step  <= '0;
                    r_state <= S_LOAD;
                  end else begin
                    r_state <= S_FINISH;
                    r_done  <= 1'b1;
                  end
                end else begin
                  r_step  <= r_step + AW'(1);
                  r_state <= S_LOAD;
                end
              end else begin
                r_tick <= r_tick + DUR_W'(1);
              end
            end else begin
              r_pre <= r_pre + PW'(1);
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
            r_keys  <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_keys  <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_space = r_keys[2];
  assign key_right = r_keys[1];
  assign key_left  = r_keys[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign step_idx  = r_step;

endmodule

// File: tb/tb_key_script_sequencer.sv
// Directed bench for key_script_sequencer with STEPS=4, TICK_DIV=4, DUR_W=8.
module tb_key_script_sequencer;

  localparam int STEPS    = 4;
  localparam int DUR_W    = 8;
  localparam int TICK_DIV = 4;
  localparam int AW       = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [2:0]       wr_keys;
  logic [DUR_W-1:0] wr_dur;
  logic             wr_last;
  logic             start;
  logic             abort;
  logic             loop_en;
  logic             key_space;
  logic             key_right;
  logic             key_left;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step_idx;

  int n_vec = 0;
  int n_err = 0;

  key_script_sequencer #(
    .STEPS   (STEPS),
    .DUR_W   (DUR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_keys  (wr_keys),
    .wr_dur   (wr_dur),
    .wr_last  (wr_last),
    .start    (start),
    .abort    (abort),
    .loop_en  (loop_en),
    .key_space(key_space),
    .key_right(key_right),
    .key_left (key_left),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [2:0] k, input int dur, input logic last);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_keys = k;
    wr_dur  = DUR_W'(dur);
    wr_last = last;
    clk1();
    wr_en   = 1'b0;
  endtask

  // n cycles with mask k held; done expected only on the final cycle when done_last is set.
  task automatic play(input string tag, input int n, input logic [2:0] k,
                      input logic done_last, input int step);
    for (int i = 0; i < n; i++) begin
      clk1();
      check($sformatf("%s keys c%0d", tag, i), {key_space, key_right, key_left}, k);
      check($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
      check($sformatf("%s done c%0d", tag, i), done, (done_last && (i == n - 1)));
      if (i < n - 1) check($sformatf("%s step c%0d", tag, i), step_idx, step);
    end
  endtask

  task automatic do_start(input string tag, input logic hold);
    start = 1'b1;
    clk1();
    if (!hold) start = 1'b0;
    check({tag, " load busy"}, busy, 1'b1);
    check({tag, " load keys"}, {key_space, key_right, key_left}, 3'b000);
    check({tag, " load step"}, step_idx, 0);
  endtask

  task automatic idle_chk(input string tag, input int step);
    clk1();
    check({tag, " idle keys"}, {key_space, key_right, key_left}, 3'b000);
    check({tag, " idle busy"}, busy, 1'b0);
    check({tag, " idle done"}, done, 1'b0);
    check({tag, " idle step"}, step_idx, step);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_keys = '0; wr_dur = '0; wr_last = 1'b0;
    start = 1'b1; abort = 1'b0; loop_en = 1'b0;

    // reset with start asserted
    for (int i = 0; i < 2; i++) begin
      clk1();
      check("rst keys", {key_space, key_right, key_left}, 3'b000);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst step", step_idx, 0);
    end
    start = 1'b0;
    rst   = 1'b0;
    idle_chk("post rst", 0);

    // basic two-step script
    wr(0, 3'b100, 3, 1'b0);
    wr(1, 3'b010, 2, 1'b1);
    do_start("t2", 1'b0);
    play("t2 e0", 13, 3'b100, 1'b0, 0);
    play("t2 e1", 9, 3'b010, 1'b1, 1);
    idle_chk("t2", 1);

    // loop once, then drop loop_en during the second pass
    loop_en = 1'b1;
    do_start("t3", 1'b0);
    play("t3 e0a", 13, 3'b100, 1'b0, 0);
    play("t3 e1a", 9, 3'b010, 1'b0, 1);
    check("t3 loop step", step_idx, 0);
    loop_en = 1'b0;
    play("t3 e0b", 13, 3'b100, 1'b0, 0);
    play("t3 e1b", 9, 3'b010, 1'b1, 1);
    idle_chk("t3", 1);

    // abort on the 5th cycle of e0, then replay
    do_start("t4", 1'b0);
    play("t4 e0", 4, 3'b100, 1'b0, 0);
    clk1();
    abort = 1'b1;
    check("t4 abort cyc keys", {key_space, key_right, key_left}, 3'b100);
    idle_chk("t4 abort", 0);
    abort = 1'b0;
    idle_chk("t4 still idle", 0);
    do_start("t4r", 1'b0);
    play("t4r e0", 13, 3'b100, 1'b0, 0);
    play("t4r e1", 9, 3'b010, 1'b1, 1);
    idle_chk("t4r", 1);

    // zero duration behaves as one tick
    wr(0, 3'b001, 0, 1'b1);
    do_start("t5", 1'b0);
    play("t5 e0", 5, 3'b001, 1'b1, 0);
    idle_chk("t5", 0);

    // start held through playback, e1 rewritten while e0 plays
    wr(0, 3'b100, 3, 1'b0);
    do_start("t6", 1'b1);
    play("t6 e0a", 3, 3'b100, 1'b0, 0);
    wr_en = 1'b1; wr_addr = 2'd1; wr_keys = 3'b011; wr_dur = 8'd2; wr_last = 1'b1;
    play("t6 e0w", 1, 3'b100, 1'b0, 0);
    wr_en = 1'b0;
    play("t6 e0b", 9, 3'b100, 1'b0, 0);
    start = 1'b0;
    play("t6 e1", 9, 3'b011, 1'b1, 1);
    idle_chk("t6", 1);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    idle_chk("t6 sa1", 1);
    idle_chk("t6 sa2", 1);
    start = 1'b0;
    abort = 1'b0;
    idle_chk("t6 end", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
